// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 raster path, plus the colour
// palette used by the pixel-colour block controllers.
package vga_timing_pkg;

  // Counter word used for hCount / vCount everywhere in the display path
  typedef logic [9:0] count_t;

  // 12-bit RGB (4:4:4) colour word driven by the block controllers
  typedef logic [11:0] rgb_t;

  // Default 640x480@60 timing, board clock 100 MHz, pixel clock 25 MHz
  localparam int CLK_DIV = 4;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  // Inclusive edges of the visible window with the default timing
  localparam count_t HV_X0 = count_t'(H_SYNC + H_BP);
  localparam count_t HV_X1 = count_t'(H_SYNC + H_BP + H_ACT - 1);
  localparam count_t HV_Y0 = count_t'(V_SYNC + V_BP);
  localparam count_t HV_Y1 = count_t'(V_SYNC + V_BP + V_ACT - 1);

  // Palette shared with the block controllers
  localparam rgb_t COLOR_BLACK  = 12'h000;
  localparam rgb_t COLOR_WHITE  = 12'hFFF;
  localparam rgb_t COLOR_RED    = 12'hF00;
  localparam rgb_t COLOR_GREEN  = 12'h0F0;
  localparam rgb_t COLOR_BLUE   = 12'h00F;
  localparam rgb_t COLOR_YELLOW = 12'hFF0;

  // A frame dimension is usable only if every count 0..total-1 fits a count_t
  function automatic bit fitsCounter(input int total);
    return (total > 0) && (total <= (1 << $bits(count_t)));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing generator drives it, the sync connector
// and the pixel-colour controllers consume it.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   hSync;
  logic   vSync;
  logic   bright;
  count_t hCount;
  count_t vCount;
  logic   pix_tick;
  logic   frame_tick;

  modport master (
    output hSync, vSync, bright, hCount, vCount, pix_tick, frame_tick
  );

  modport slave (
    input  hSync, vSync, bright, hCount, vCount, pix_tick, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Clock-enable divider: a one-clk pulse on the last board clock of every
// DIV-clock period, so the pixel logic runs on the board clock with an enable.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] L_LAST = W'(DIV - 1);

  logic [W-1:0] r_div;

  if (DIV < 2) begin : g_badDiv
    $error("clk_en_div: DIV must be at least 2");
  end

  // Free-running 0..DIV-1 count, cleared straight away by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_div == L_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_tick = (r_div == L_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: walks (hCount, vCount) over the full frame at the
// pixel rate and decodes syncs, the visible window and the frame pulse
// directly from the registered counters.
module vga_timing_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int H_ACT   = vga_timing_pkg::H_ACT,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP,
  parameter int V_ACT   = vga_timing_pkg::V_ACT,
  parameter int V_FP    = vga_timing_pkg::V_FP
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam count_t L_H_LAST = count_t'(H_TOT - 1);
  localparam count_t L_V_LAST = count_t'(V_TOT - 1);
  localparam count_t L_H_SYNC = count_t'(H_SYNC);
  localparam count_t L_V_SYNC = count_t'(V_SYNC);
  // Window bounds: X0/Y0 inclusive, XE/YE exclusive
  localparam count_t L_X0 = count_t'(H_SYNC + H_BP);
  localparam count_t L_XE = count_t'(H_SYNC + H_BP + H_ACT);
  localparam count_t L_Y0 = count_t'(V_SYNC + V_BP);
  localparam count_t L_YE = count_t'(V_SYNC + V_BP + V_ACT);

  if (!(CLK_DIV >= 2 && fitsCounter(H_TOT) && fitsCounter(V_TOT))) begin : g_badParams
    $error("vga_timing_gen: CLK_DIV < 2 or a frame dimension exceeds the 10-bit counters");
  end

  logic   w_pixTick;
  logic   w_hLast;
  logic   w_vLast;
  count_t r_hCount;
  count_t r_vCount;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_pixDiv (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_pixTick)
  );

  assign w_hLast = (r_hCount == L_H_LAST);
  assign w_vLast = (r_vCount == L_V_LAST);

  // Column counter: one step per pixel period, wrapping at the end of a line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hCount <= '0;
    end else if (w_pixTick) begin
      r_hCount <= w_hLast ? '0 : r_hCount + 1'b1;
    end
  end

  // Line counter: steps only on the edge where the column counter wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vCount <= '0;
    end else if (w_pixTick && w_hLast) begin
      r_vCount <= w_vLast ? '0 : r_vCount + 1'b1;
    end
  end

  // Decodes come straight off the counter registers, so they change only on
  // pixel boundaries and stay stable for a full pixel period.
  assign vga.hSync      = !(r_hCount < L_H_SYNC);
  assign vga.vSync      = !(r_vCount < L_V_SYNC);
  assign vga.bright     = (r_hCount >= L_X0) && (r_hCount < L_XE) &&
                          (r_vCount >= L_Y0) && (r_vCount < L_YE);
  assign vga.hCount     = r_hCount;
  assign vga.vCount     = r_vCount;
  assign vga.pix_tick   = w_pixTick;
  assign vga.frame_tick = w_pixTick && w_hLast && w_vLast;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default-timing instance for the
// reset, line and sync checks, and a shrunken instance (CLK_DIV=2, 17x11
// frame) so that several full frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if busA ();
  vga_timing_gen_if busB ();

  vga_timing_gen dutA (
    .clk (clk),
    .rst (rst),
    .vga (busA)
  );

  // Small frame: H 4+3+8+2 = 17, V 2+3+5+1 = 11, visible cols 7..14, lines 5..9
  vga_timing_gen #(
    .CLK_DIV (2),
    .H_SYNC  (4),
    .H_BP    (3),
    .H_ACT   (8),
    .H_FP    (2),
    .V_SYNC  (2),
    .V_BP    (3),
    .V_ACT   (5),
    .V_FP    (1)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .vga (busB)
  );

  typedef struct {
    string name;
    int    edges;
    int    h;
    int    v;
    int    hs;
    int    vs;
    int    br;
    int    pt;
  } vec_t;

  vec_t vecs[10];
  int   passCount  = 0;
  int   totalCount = 0;
  int   curEdge    = 0;

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance to the given number of clk edges after reset release, sample #1 later
  task automatic applyStimulus(input int edges);
    while (curEdge < edges) begin
      @(posedge clk);
      curEdge++;
    end
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
    curEdge = 0;
    #1;
  endtask

  int bCnt, vsCnt, ptCnt, hsCnt, brCnt, vsLowLine;
  int firstH, firstV, lastH, lastV;
  int tickAt[$];

  initial begin
    // Default-timing expectations, counted in clk edges after reset release
    vecs[0] = '{"reset state",      0,    0, 0, 0, 0, 0, 0};
    vecs[1] = '{"first pix_tick",   3,    0, 0, 0, 0, 0, 1};
    vecs[2] = '{"first h step",     4,    1, 0, 0, 0, 0, 0};
    vecs[3] = '{"last hsync col",   383,  95, 0, 0, 0, 0, 1};
    vecs[4] = '{"hsync rises",      384,  96, 0, 1, 0, 0, 0};
    vecs[5] = '{"line0 end",        3199, 799, 0, 1, 0, 0, 1};
    vecs[6] = '{"h wrap v step",    3200, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{"line1 end",        6399, 799, 1, 1, 0, 0, 1};
    vecs[8] = '{"vsync rises",      6400, 0, 2, 0, 1, 0, 0};
    vecs[9] = '{"col144 line2 dark", 6976, 144, 2, 1, 1, 0, 0};

    // Reset asserted mid-line clears everything in the same cycle
    #12;
    releaseReset();
    applyStimulus(1600);
    checkOutput("pre-reset hCount", int'(busA.hCount), 400);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst hCount", int'(busA.hCount), 0);
    checkOutput("async rst vCount", int'(busA.vCount), 0);
    checkOutput("async rst hSync",  int'(busA.hSync), 0);
    checkOutput("async rst vSync",  int'(busA.vSync), 0);
    checkOutput("async rst bright", int'(busA.bright), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("held rst pix_tick",   int'(busA.pix_tick), 0);
    checkOutput("held rst frame_tick", int'(busA.frame_tick), 0);
    releaseReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].edges);
      checkOutput({vecs[i].name, " hCount"}, int'(busA.hCount), vecs[i].h);
      checkOutput({vecs[i].name, " vCount"}, int'(busA.vCount), vecs[i].v);
      checkOutput({vecs[i].name, " hSync"},  int'(busA.hSync),  vecs[i].hs);
      checkOutput({vecs[i].name, " vSync"},  int'(busA.vSync),  vecs[i].vs);
      checkOutput({vecs[i].name, " bright"}, int'(busA.bright), vecs[i].br);
      checkOutput({vecs[i].name, " pix_tick"}, int'(busA.pix_tick), vecs[i].pt);
    end

    // Line 3 in full: hSync low for exactly 96 pixels of 4 clks
    applyStimulus(9600);
    hsCnt = 0; brCnt = 0; vsLowLine = 0; ptCnt = 0;
    for (int i = 0; i < 3200; i++) begin
      if (!busA.hSync)  hsCnt++;
      if (busA.bright)  brCnt++;
      if (!busA.vSync)  vsLowLine++;
      if (busA.pix_tick) ptCnt++;
      applyStimulus(curEdge + 1);
    end
    checkOutput("line3 hSync low clks", hsCnt, 384);
    checkOutput("line3 bright clks", brCnt, 0);
    checkOutput("line3 vSync low clks", vsLowLine, 0);
    checkOutput("line3 pix_ticks", ptCnt, 800);
    checkOutput("line4 start vCount", int'(busA.vCount), 4);

    // Small-frame instance: three complete frames from a fresh reset
    #2 rst = 1'b1;
    #1;
    checkOutput("B rst hCount", int'(busB.hCount), 0);
    releaseReset();
    bCnt = 0; vsCnt = 0; ptCnt = 0;
    firstH = -1; firstV = -1; lastH = -1; lastV = -1;
    for (int k = 0; k < 1126; k++) begin
      if (k < 374) begin
        if (busB.bright) begin
          bCnt++;
          if (firstH < 0) begin
            firstH = int'(busB.hCount);
            firstV = int'(busB.vCount);
          end
          lastH = int'(busB.hCount);
          lastV = int'(busB.vCount);
        end
        if (!busB.vSync)   vsCnt++;
        if (busB.pix_tick) ptCnt++;
      end
      if (busB.frame_tick) begin
        tickAt.push_back(k);
        checkOutput("B tick hCount",   int'(busB.hCount), 16);
        checkOutput("B tick vCount",   int'(busB.vCount), 10);
        checkOutput("B tick pix_tick", int'(busB.pix_tick), 1);
      end
      applyStimulus(curEdge + 1);
    end
    checkOutput("B bright clks/frame", bCnt, 80);
    checkOutput("B first bright h", firstH, 7);
    checkOutput("B first bright v", firstV, 5);
    checkOutput("B last bright h",  lastH, 14);
    checkOutput("B last bright v",  lastV, 9);
    checkOutput("B vSync low clks/frame", vsCnt, 68);
    checkOutput("B pix_ticks/frame", ptCnt, 187);
    checkOutput("B frame_tick count", tickAt.size(), 3);
    if (tickAt.size() == 3) begin
      checkOutput("B first frame_tick clk", tickAt[0], 373);
      checkOutput("B frame period 1", tickAt[1] - tickAt[0], 374);
      checkOutput("B frame period 2", tickAt[2] - tickAt[1], 374);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
